fetch_sequencer: RTL

//  Front-end controller that drives the fetch side of fetch_if. It generates sequential PCs,

---
 rtl/core_pkg.sv | 32 +++
 rtl/fetch_buffer.sv | 88 ++++++++
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core front-end types.
//   XLEN / ILEN          : address and instruction widths
//   INSTR_BYTES          : size of one fetched instruction
//   core_instr_packet_t  : packet handed from fetch to the instruction window
//   fetch_state_e        : fetch sequencer FSM states
//   next_pc()            : sequential PC increment (wraps modulo 2^XLEN)
package core_pkg;

  localparam int XLEN        = 32;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Fetch fills only pc and instr; the remaining fields belong to later
  // stages and leave fetch as zero.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
    logic            fault;
  } core_instr_packet_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } fetch_state_e;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch packets between memory responses and the
// instruction window.
//   clock, reset  : core clock, asynchronous active-high reset
//   push_i        : write push_data_i at the tail
//   push_data_i   : packet to write
//   pop_i         : consumer took the head (ignored when empty)
//   flush_i       : discard all entries; wins over push and pop
//   count_o       : current occupancy
//   head_o        : packet at the head (registered storage)
//   empty_o       : no entries
module fetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push_i,
  input  core_instr_packet_t             push_data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output core_instr_packet_t             head_o,
  output logic                           empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  core_instr_packet_t mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A pop at full frees the slot the same-cycle push writes into.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which
  // entries are meaningful, so clearing the data would only cost flops.
  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    push_i |-> (count_q != CW'(DEPTH)) || pop_i || flush_i);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: generates sequential PCs, issues instruction-memory
// requests under a credit limit, tags in-order responses with their PC,
// buffers them and hands them to the instruction window. Redirects flush
// the buffer and drop responses to requests issued before the redirect.
//   clock, reset            : core clock, asynchronous active-high reset
//   imem_req_valid/ready    : request handshake, imem_req_addr = fetch PC
//   imem_rsp_valid/data     : in-order responses, no backpressure
//   redirect_valid/pc       : branch/exception redirect to a new PC
//   fetch_halt              : stop issuing requests
//   fetch_idle              : halted with nothing in flight or to drop
//   fetch_iw_valid/iw_fetch_ready/fetch_iw_instr_packet : packet handshake
module fetch_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [ILEN-1:0]    imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               fetch_halt,
  output logic               fetch_idle,
  output logic               fetch_iw_valid,
  input  logic               iw_fetch_ready,
  output core_instr_packet_t fetch_iw_instr_packet
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]      outst_q, outst_d;
  logic [CW-1:0]      drop_q, drop_d;
  logic               idle_q, idle_d;
  logic [CW-1:0]      buf_count;
  logic               buf_empty;
  logic [SW-1:0]      credit_used;
  logic               req_accept, req_held;
  logic               rsp_drop, rsp_take;
  core_instr_packet_t push_pkt;

  // Every slot is reserved from issue until the packet leaves the buffer,
  // so a response can never find the buffer full.
  assign credit_used    = SW'(outst_q) + SW'(drop_q) + SW'(buf_count);
  assign imem_req_valid = (state_q == S_RUN) && !redirect_valid &&
                          (credit_used < SW'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_accept     = imem_req_valid & imem_req_ready;
  assign req_held       = imem_req_valid & ~imem_req_ready;

  // Stale responses are consumed first; a response with nothing counted
  // against it is ignored (and flagged below).
  assign rsp_drop = imem_rsp_valid & (drop_q != '0);
  assign rsp_take = imem_rsp_valid & (drop_q == '0) & (outst_q != '0);

  always_comb begin
    push_pkt       = '0;
    push_pkt.pc    = rsp_pc_q;
    push_pkt.instr = imem_rsp_data;
  end

  // Halting waits for a presented request to be accepted so the address
  // never changes under a pending handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = fetch_halt ? S_HALT : S_RUN;
      S_RUN:   if (fetch_halt && !req_held) state_d = S_HALT;
      S_HALT:  if (!fetch_halt) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q - CW'(rsp_drop);
    outst_d  = outst_q + CW'(req_accept) - CW'(rsp_take);
    if (req_accept) pc_d = next_pc(pc_q);
    if (rsp_take)   rsp_pc_d = next_pc(rsp_pc_q);
    if (redirect_valid) begin
      // Everything still in flight becomes stale; a response taken this
      // cycle was already flushed with the buffer so it is not counted.
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = drop_q - CW'(rsp_drop) + outst_q + CW'(req_accept) - CW'(rsp_take);
      outst_d  = '0;
    end
    idle_d = (state_d == S_HALT) && (outst_d == '0) && (drop_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      idle_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      idle_q   <= idle_d;
    end
  end

  assign fetch_idle     = idle_q;
  assign fetch_iw_valid = !buf_empty;

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_buffer (
    .clock       (clock),
    .reset       (reset),
    .push_i      (rsp_take),
    .push_data_i (push_pkt),
    .pop_i       (fetch_iw_valid & iw_fetch_ready),
    .flush_i     (redirect_valid),
    .count_o     (buf_count),
    .head_o      (fetch_iw_instr_packet),
    .empty_o     (buf_empty)
  );

  a_rsp_expected : assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> (outst_q != '0) || (drop_q != '0));

endmodule
